// File: rtl/ltc2324_16_emu.sv
// Responder-side emulation of the LTC2324-16 quad-channel serial ADC interface.
// CNV and SCK are oversampled on clk; the sample words come from ch*_in or from an internal ramp.
module ltc2324_16_emu #(
  parameter int          TCONV_CYCLES = 24,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] RAMP_STEP    = 16'h0001,
  parameter logic [15:0] CH_OFFSET    = 16'h1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CNV,
  input  logic        SCK,
  input  logic        pattern_sel,
  input  logic [15:0] ch1_in,
  input  logic [15:0] ch2_in,
  input  logic [15:0] ch3_in,
  input  logic [15:0] ch4_in,
  output logic        CLKOUT,
  output logic        SDO1,
  output logic        SDO2,
  output logic        SDO3,
  output logic        SDO4,
  output logic        busy,
  output logic        frame_done,
  output logic        abort
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, SHIFT = 2'd2} state_t;

  localparam int                CNT_W    = (TCONV_CYCLES > 1) ? $clog2(TCONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCONV_CYCLES - 1);

  // Channel N of the ramp pattern sits N-1 offsets above the common ramp, modulo 2^16.
  function automatic logic [15:0] ramp_word(input logic [15:0] base, input logic [1:0] idx);
    return base + CH_OFFSET * 16'(idx);
  endfunction

  logic [SYNC_STAGES-1:0] cnv_sync, sck_sync;
  logic                   cnv_prev, sck_prev;
  logic                   cnv_rise, sck_rise;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [3:0]        bit_cnt, bit_n;
  logic [15:0]       ramp, ramp_n;
  logic [3:0][15:0]  sr, sr_n;
  logic [3:0][15:0]  ch_word;
  logic [3:0]        sdo_q, sdo_n;
  logic              busy_n, done_n, abort_n, clkout_n;
  logic              load, last_bit;

  assign ch_word  = {ch4_in, ch3_in, ch2_in, ch1_in};
  assign cnv_rise = cnv_sync[SYNC_STAGES-1] & ~cnv_prev;
  assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_prev;

  // Input synchronizers plus one edge-detect flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnv_sync <= '0;
      sck_sync <= '0;
      cnv_prev <= 1'b0;
      sck_prev <= 1'b0;
    end else begin
      cnv_sync <= {cnv_sync[SYNC_STAGES-2:0], CNV};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cnv_prev <= cnv_sync[SYNC_STAGES-1];
      sck_prev <= sck_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_cnt;
    ramp_n   = ramp;
    sr_n     = sr;
    busy_n   = busy;
    done_n   = 1'b0;
    abort_n  = 1'b0;
    load     = 1'b0;
    last_bit = 1'b0;

    case (state)
      IDLE: load = cnv_rise;
      CONV: begin
        if (cnt == CNT_LAST) begin
          busy_n  = 1'b0;
          bit_n   = '0;
          state_n = SHIFT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT: begin
        last_bit = sck_rise && (bit_cnt == 4'd15);
        if (sck_rise) begin
          for (int i = 0; i < 4; i++) sr_n[i] = {sr[i][14:0], 1'b0};
          bit_n = bit_cnt + 4'd1;
        end
        if (last_bit) begin
          done_n  = 1'b1;
          ramp_n  = ramp + RAMP_STEP;
          state_n = IDLE;
        end
        // A CNV edge on the final bit completes the frame first, so it is not an abort.
        if (cnv_rise) begin
          abort_n = ~last_bit;
          load    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      for (int i = 0; i < 4; i++)
        sr_n[i] = pattern_sel ? ramp_word(ramp_n, 2'(i)) : ch_word[i];
      cnt_n   = '0;
      bit_n   = '0;
      busy_n  = 1'b1;
      state_n = CONV;
    end

    for (int i = 0; i < 4; i++) sdo_n[i] = (state_n == SHIFT) & sr_n[i][15];
    // SCK as sampled while shifting, so the 16th pulse is still echoed as the frame closes.
    clkout_n = (state == SHIFT) & sck_sync[SYNC_STAGES-1];
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      ramp       <= '0;
      sr         <= '0;
      sdo_q      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
      CLKOUT     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_n;
      ramp       <= ramp_n;
      sr         <= sr_n;
      sdo_q      <= sdo_n;
      busy       <= busy_n;
      frame_done <= done_n;
      abort      <= abort_n;
      CLKOUT     <= clkout_n;
    end
  end

  assign SDO1 = sdo_q[0];
  assign SDO2 = sdo_q[1];
  assign SDO3 = sdo_q[2];
  assign SDO4 = sdo_q[3];

endmodule

// File: tb/tb_ltc2324_16_emu.sv
// Bench for ltc2324_16_emu: acts as the ADC driver and scoreboards the serialized words.
module tb_ltc2324_16_emu;

  localparam int          TCONV  = 24;
  localparam logic [15:0] CH_OFF = 16'h1000;

  logic        clk = 1'b0;
  logic        rst_n, CNV, SCK, pattern_sel;
  logic [15:0] ch1_in, ch2_in, ch3_in, ch4_in;
  logic        CLKOUT, SDO1, SDO2, SDO3, SDO4, busy, frame_done, abort;

  always #5 clk = ~clk;

  ltc2324_16_emu #(
    .TCONV_CYCLES(TCONV),
    .SYNC_STAGES (2),
    .RAMP_STEP   (16'h0001),
    .CH_OFFSET   (CH_OFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CNV        (CNV),
    .SCK        (SCK),
    .pattern_sel(pattern_sel),
    .ch1_in     (ch1_in),
    .ch2_in     (ch2_in),
    .ch3_in     (ch3_in),
    .ch4_in     (ch4_in),
    .CLKOUT     (CLKOUT),
    .SDO1       (SDO1),
    .SDO2       (SDO2),
    .SDO3       (SDO3),
    .SDO4       (SDO4),
    .busy       (busy),
    .frame_done (frame_done),
    .abort      (abort)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb[$];
  logic [15:0] m_ramp;
  int          fd_cnt = 0, ab_cnt = 0, ck_rise = 0;
  logic        ck_d = 1'b0;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (abort) ab_cnt++;
    if (CLKOUT && !ck_d) ck_rise++;
    ck_d = CLKOUT;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] outs();
    return {SDO4, SDO3, SDO2, SDO1, CLKOUT, busy, frame_done, abort};
  endfunction

  function automatic logic [3:0] sdo_vec();
    return {SDO4, SDO3, SDO2, SDO1};
  endfunction

  task automatic push_ch();
    sb.push_back({ch4_in, ch3_in, ch2_in, ch1_in});
  endtask

  task automatic push_ramp(input logic [15:0] r);
    logic [15:0] w1, w2, w3;
    w1 = r + CH_OFF;
    w2 = w1 + CH_OFF;
    w3 = w2 + CH_OFF;
    sb.push_back({w3, w2, w1, r});
  endtask

  task automatic start_conv();
    CNV = 1'b1;
    tick(2);
    CNV = 1'b0;
  endtask

  // mode 1: CNV re-pulse and input change mid-conversion; mode 2: SCK bursts during conversion
  task automatic wait_ready(input int mode, output int blen);
    int guard;
    blen  = 0;
    guard = 0;
    while (!busy && guard < 20) begin tick(1); guard++; end
    while (busy && guard < 200) begin
      if (mode == 1 && blen == 10) begin
        CNV = 1'b1;
        ch1_in = ~ch1_in; ch2_in = ~ch2_in; ch3_in = ~ch3_in; ch4_in = ~ch4_in;
      end
      if (mode == 1 && blen == 12) CNV = 1'b0;
      if (mode == 2) SCK = (blen < 17) && ((blen % 4) >= 2);
      blen++;
      tick(1);
      guard++;
    end
    SCK = 1'b0;
    CNV = 1'b0;
    if (guard >= 200 || blen == 0) chk("ready_timeout", guard, 0);
  endtask

  task automatic read_bits(input int n, input bit cnv_last, input bit chk_ck,
                           output logic [3:0][15:0] got);
    logic [3:0] s;
    got = '0;
    for (int b = 0; b < n; b++) begin
      s = sdo_vec();
      for (int c = 0; c < 4; c++) got[c] = {got[c][14:0], s[c]};
      SCK = 1'b1;
      if (cnv_last && b == n - 1) CNV = 1'b1;
      if (chk_ck && b == 0) begin
        tick(2);
        chk("clkout_lag", CLKOUT, 0);
        tick(1);
        chk("clkout_hi", CLKOUT, 1);
        tick(1);
      end else begin
        tick(4);
      end
      SCK = 1'b0;
      CNV = 1'b0;
      tick(4);
    end
  endtask

  task automatic cmp_frame(input int n, input logic [3:0][15:0] got);
    logic [63:0] e;
    logic [15:0] ew;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        ew = e[c*16 +: 16];
        chk($sformatf("ch%0d_n%0d", c + 1, n), {16'h0, got[c]}, {16'h0, ew >> (16 - n)});
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    m_ramp = 16'h0;
    tick(2);
  endtask

  initial begin
    logic [3:0][15:0] got;
    logic [63:0]      dropped;
    int               blen, fd0, ab0, ck0, quiet;

    rst_n = 1'b0; CNV = 1'b0; SCK = 1'b0; pattern_sel = 1'b0;
    ch1_in = '0; ch2_in = '0; ch3_in = '0; ch4_in = '0;
    m_ramp = 16'h0;
    tick(3);
    chk("reset_outs", {24'h0, outs()}, 0);
    rst_n = 1'b1;
    tick(2);

    // Test 1: external words
    ch1_in = 16'hA5C3; ch2_in = 16'h0001; ch3_in = 16'h8000; ch4_in = 16'hFFFF;
    push_ch();
    fd0 = fd_cnt; ck0 = ck_rise;
    start_conv();
    wait_ready(0, blen);
    chk("t1_busy_len", blen, TCONV);
    read_bits(16, 0, 0, got);
    cmp_frame(16, got);
    tick(2);
    chk("t1_frame_done", fd_cnt - fd0, 1);
    chk("t1_sdo_after", {28'h0, sdo_vec()}, 0);
    chk("t1_clkout_rises", ck_rise - ck0, 16);

    // Test 2: three ramp frames from reset
    do_reset();
    pattern_sel = 1'b1;
    for (int f = 0; f < 3; f++) begin
      push_ramp(m_ramp);
      start_conv();
      wait_ready(0, blen);
      read_bits(16, 0, 0, got);
      cmp_frame(16, got);
      m_ramp = m_ramp + 16'h1;
    end

    // Test 3: CNV during conversion is ignored
    pattern_sel = 1'b0;
    ch1_in = 16'h1234; ch2_in = 16'h5678; ch3_in = 16'h9ABC; ch4_in = 16'hDEF0;
    push_ch();
    ab0 = ab_cnt;
    start_conv();
    wait_ready(1, blen);
    chk("t3_busy_len", blen, TCONV);
    read_bits(16, 0, 0, got);
    cmp_frame(16, got);
    chk("t3_no_abort", ab_cnt - ab0, 0);
    m_ramp = m_ramp + 16'h1;

    // Test 4: short read aborted by a new CNV
    pattern_sel = 1'b1;
    push_ramp(m_ramp);
    start_conv();
    wait_ready(0, blen);
    ab0 = ab_cnt; fd0 = fd_cnt;
    read_bits(7, 0, 0, got);
    cmp_frame(7, got);
    push_ramp(m_ramp);
    start_conv();
    wait_ready(0, blen);
    chk("t4_abort", ab_cnt - ab0, 1);
    read_bits(16, 0, 0, got);
    cmp_frame(16, got);
    chk("t4_frame_done", fd_cnt - fd0, 1);
    m_ramp = m_ramp + 16'h1;

    // Test 5: stray SCK in IDLE and CONV
    ck0 = ck_rise; fd0 = fd_cnt; quiet = 0;
    for (int p = 0; p < 20; p++) begin
      SCK = 1'b1;
      tick(2);
      if (sdo_vec() != 4'h0 || CLKOUT) quiet++;
      SCK = 1'b0;
      tick(2);
    end
    chk("t5_idle_quiet", quiet, 0);
    chk("t5_idle_clkout", ck_rise - ck0, 0);
    push_ramp(m_ramp);
    start_conv();
    wait_ready(2, blen);
    chk("t5_busy_len", blen, TCONV);
    chk("t5_conv_clkout", ck_rise - ck0, 0);
    read_bits(16, 0, 1, got);
    cmp_frame(16, got);
    chk("t5_clkout_rises", ck_rise - ck0, 16);
    chk("t5_frame_done", fd_cnt - fd0, 1);
    m_ramp = m_ramp + 16'h1;

    // CNV coinciding with the final SCK edge
    push_ramp(m_ramp);
    push_ramp(m_ramp + 16'h1);
    start_conv();
    wait_ready(0, blen);
    fd0 = fd_cnt; ab0 = ab_cnt;
    read_bits(16, 1, 0, got);
    cmp_frame(16, got);
    m_ramp = m_ramp + 16'h1;
    chk("tc_frame_done", fd_cnt - fd0, 1);
    chk("tc_no_abort", ab_cnt - ab0, 0);
    wait_ready(0, blen);
    read_bits(16, 0, 0, got);
    cmp_frame(16, got);
    m_ramp = m_ramp + 16'h1;

    // Test 6: reset mid-frame
    pattern_sel = 1'b0;
    ch1_in = 16'hFFFF; ch2_in = 16'hFFFF; ch3_in = 16'hFFFF; ch4_in = 16'hFFFF;
    push_ch();
    start_conv();
    wait_ready(0, blen);
    read_bits(8, 0, 0, got);
    chk("t6_pre_reset_sdo", {28'h0, sdo_vec()}, 32'hF);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outs", {24'h0, outs()}, 0);
    dropped = sb.pop_front();
    tick(2);
    rst_n = 1'b1;
    m_ramp = 16'h0;
    tick(2);
    pattern_sel = 1'b1;
    push_ramp(m_ramp);
    start_conv();
    wait_ready(0, blen);
    read_bits(16, 0, 0, got);
    cmp_frame(16, got);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
